// File: rtl/fir_down_sample_pack.sv
// Decimates the low-pass sample stream by N+1 and packs PACK_NUM kept samples per word into a FWFT FIFO.
// Latency: word-completing input at T -> ds_data_vld_o at T+2 when the FIFO is empty; valid/ready drain.
// Backpressure: full FIFO drops the word (sticky ds_overflow_o); FIR_DS_PACK_FLUSH_EN flushes partial words at stop.
module fir_down_sample_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK_NUM   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           laser_start_i,
  input  logic [7:0]                     fir_down_sample_num_i,
  input  logic                           lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0]          lp_laser_data_i,
  output logic                           ds_data_vld_o,
  output logic [DATA_WIDTH*PACK_NUM-1:0] ds_data_o,
  input  logic                           ds_data_rdy_i,
  output logic                           ds_overflow_o,
  output logic [31:0]                    ds_word_cnt_o
);

  localparam int WW = DATA_WIDTH * PACK_NUM;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(PACK_NUM);
  localparam logic [4:0]    N_MAX     = 5'd19;
  localparam logic [IW-1:0] LAST_LANE = IW'(PACK_NUM - 1);

  logic          start_q;
  logic          rise;
  logic [4:0]    n_lat;
  logic [4:0]    n_clamp;
  logic [4:0]    n_eff;
  logic [4:0]    ph;
  logic [IW-1:0] idx;
  logic [WW-1:0] pack_q;
  logic [WW-1:0] pack_nxt;
  logic [WW-1:0] word_q;
  logic          wr_vld;

  assign rise    = laser_start_i && !start_q;
  assign n_clamp = (fir_down_sample_num_i > 8'd19) ? N_MAX : fir_down_sample_num_i[4:0];
  // The window is latched on the rising edge, so that cycle must already use the new value.
  assign n_eff   = rise ? n_clamp : n_lat;

  always_comb begin
    pack_nxt = pack_q;
    pack_nxt[idx*DATA_WIDTH +: DATA_WIDTH] = lp_laser_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      n_lat   <= '0;
      ph      <= '0;
      idx     <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      wr_vld  <= 1'b0;
    end else begin
      start_q <= laser_start_i;
      wr_vld  <= 1'b0;
      if (rise) begin
        n_lat <= n_clamp;
      end
      if (!laser_start_i) begin
        ph     <= '0;
        idx    <= '0;
        pack_q <= '0;
`ifdef FIR_DS_PACK_FLUSH_EN
        if (start_q && (idx != '0)) begin
          word_q <= pack_q;
          wr_vld <= 1'b1;
        end
`endif
      end else if (lp_laser_vld_i) begin
        if (ph == n_eff) begin
          ph <= '0;
          if (idx == LAST_LANE) begin
            word_q <= pack_nxt;
            wr_vld <= 1'b1;
            idx    <= '0;
            pack_q <= '0;
          end else begin
            pack_q <= pack_nxt;
            idx    <= idx + 1'b1;
          end
        end else begin
          ph <= ph + 1'b1;
        end
      end
    end
  end

  // Output FIFO: extra pointer MSB distinguishes full from empty.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [WW-1:0] last_q;
  logic          empty;
  logic          full;
  logic          rd;
  logic          wr_ok;
  logic          drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd    = !empty && ds_data_rdy_i;
  assign wr_ok = wr_vld && (!full || rd);
  assign drop  = wr_vld && full && !rd;

  assign ds_data_vld_o = !empty;
  assign ds_data_o     = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= word_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      last_q        <= '0;
      ds_overflow_o <= 1'b0;
      ds_word_cnt_o <= '0;
    end else begin
      last_q <= ds_data_o;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (rise) begin
        ds_overflow_o <= drop;
        ds_word_cnt_o <= {31'b0, wr_ok};
      end else begin
        if (drop) begin
          ds_overflow_o <= 1'b1;
        end
        if (wr_ok) begin
          ds_word_cnt_o <= ds_word_cnt_o + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_down_sample_pack.sv
// Directed bench for fir_down_sample_pack: decimation, packing, FIFO latency, overflow, stop/flush and reset.
module tb_fir_down_sample_pack;

  localparam int DW = 16;
  localparam int PN = 4;
  localparam int FD = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          laser_start_i;
  logic [7:0]    fir_down_sample_num_i;
  logic          lp_laser_vld_i;
  logic [DW-1:0] lp_laser_data_i;
  logic          ds_data_vld_o;
  logic [63:0]   ds_data_o;
  logic          ds_data_rdy_i;
  logic          ds_overflow_o;
  logic [31:0]   ds_word_cnt_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] got[$];
  logic [63:0] exp_w;
  int          exp_n;

  always #5 clk_i = ~clk_i;

  fir_down_sample_pack #(
    .DATA_WIDTH(DW),
    .PACK_NUM  (PN),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .laser_start_i        (laser_start_i),
    .fir_down_sample_num_i(fir_down_sample_num_i),
    .lp_laser_vld_i       (lp_laser_vld_i),
    .lp_laser_data_i      (lp_laser_data_i),
    .ds_data_vld_o        (ds_data_vld_o),
    .ds_data_o            (ds_data_o),
    .ds_data_rdy_i        (ds_data_rdy_i),
    .ds_overflow_o        (ds_overflow_o),
    .ds_word_cnt_o        (ds_word_cnt_o)
  );

  // Words handed over downstream, sampled mid-cycle ahead of the transferring edge.
  always @(negedge clk_i) begin
    if (!rst_i && ds_data_vld_o && ds_data_rdy_i) got.push_back(ds_data_o);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 64'hdead_dead_dead_dead;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      lp_laser_vld_i  = 1'b1;
      lp_laser_data_i = DW'(first + i);
      tick();
    end
    lp_laser_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic run_start(input logic [7:0] n);
    laser_start_i = 1'b0;
    tick();
    fir_down_sample_num_i = n;
    laser_start_i = 1'b1;
    tick();
  endtask

  initial begin
    rst_i                 = 1'b1;
    laser_start_i         = 1'b0;
    fir_down_sample_num_i = 8'd0;
    lp_laser_vld_i        = 1'b0;
    lp_laser_data_i       = '0;
    ds_data_rdy_i         = 1'b1;
    tick(2);
    check("rst_vld", 64'(ds_data_vld_o), 64'd0);
    check("rst_data", ds_data_o, 64'd0);
    check("rst_ovf", 64'(ds_overflow_o), 64'd0);
    check("rst_cnt", 64'(ds_word_cnt_o), 64'd0);
    rst_i = 1'b0;

    // 1: N=0, one word, latency T+2, then empty holds last word
    run_start(8'd0);
    got.delete();
    feed(1, 4);
    check("t1_vld_t1", 64'(ds_data_vld_o), 64'd0);
    tick();
    check("t1_vld_t2", 64'(ds_data_vld_o), 64'd1);
    check("t1_word", ds_data_o, 64'h0004_0003_0002_0001);
    check("t1_cnt", 64'(ds_word_cnt_o), 64'd1);
    tick();
    check("t1_empty_vld", 64'(ds_data_vld_o), 64'd0);
    check("t1_hold", ds_data_o, 64'h0004_0003_0002_0001);
    check("t1_nwords", 64'(got.size()), 64'd1);

    // 2: N=2, keep every third sample
    run_start(8'd2);
    check("t2_cnt_clr", 64'(ds_word_cnt_o), 64'd0);
    got.delete();
    feed(1, 24);
    tick(4);
    check("t2_nwords", 64'(got.size()), 64'd2);
    check("t2_word0", got_at(0), 64'h000c_0009_0006_0003);
    check("t2_word1", got_at(1), 64'h0018_0015_0012_000f);
    check("t2_cnt", 64'(ds_word_cnt_o), 64'd2);

    // 3: N=25 clamps to 19, keeps 20,40,60,80
    run_start(8'd25);
    got.delete();
    feed(1, 40);
    tick(4);
    check("t3_nwords_40", 64'(got.size()), 64'd0);
    feed(41, 40);
    tick(4);
    check("t3_nwords_80", 64'(got.size()), 64'd1);
    check("t3_word", got_at(0), 64'h0050_003c_0028_0014);
    check("t3_cnt", 64'(ds_word_cnt_o), 64'd1);

    // 4: overflow with rdy=0, ordered drain, restart clears
    do_reset();
    ds_data_rdy_i = 1'b0;
    run_start(8'd0);
    got.delete();
    feed(1, 68);
    tick(3);
    check("t4_ovf", 64'(ds_overflow_o), 64'd1);
    check("t4_cnt", 64'(ds_word_cnt_o), 64'd16);
    check("t4_vld", 64'(ds_data_vld_o), 64'd1);
    check("t4_head", ds_data_o, 64'h0004_0003_0002_0001);
    ds_data_rdy_i = 1'b1;
    tick(20);
    check("t4_nwords", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      exp_w = {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
      check($sformatf("t4_drain%0d", i), got_at(i), exp_w);
    end
    check("t4_ovf_sticky", 64'(ds_overflow_o), 64'd1);
    run_start(8'd0);
    check("t4_ovf_clr", 64'(ds_overflow_o), 64'd0);
    check("t4_cnt_clr", 64'(ds_word_cnt_o), 64'd0);

    // 5: full FIFO, write and read on the same edge -> no drop
    do_reset();
    ds_data_rdy_i = 1'b0;
    run_start(8'd0);
    got.delete();
    feed(1, 64);
    tick(2);
    check("t5_vld", 64'(ds_data_vld_o), 64'd1);
    feed(65, 4);
    ds_data_rdy_i = 1'b1;
    tick();
    ds_data_rdy_i = 1'b0;
    tick();
    check("t5_ovf", 64'(ds_overflow_o), 64'd0);
    check("t5_cnt", 64'(ds_word_cnt_o), 64'd17);
    ds_data_rdy_i = 1'b1;
    tick(20);
    check("t5_nwords", 64'(got.size()), 64'd17);
    check("t5_first", got_at(0), 64'h0004_0003_0002_0001);
    check("t5_last", got_at(16), 64'h0044_0043_0042_0041);

    // 6: stop after two kept samples, ignored input while idle, reset mid-run
    do_reset();
    ds_data_rdy_i = 1'b1;
    run_start(8'd0);
    got.delete();
    feed(1, 2);
    laser_start_i = 1'b0;
    tick(5);
`ifdef FIR_DS_PACK_FLUSH_EN
    exp_n = 1;
    check("t6_flush_word", got_at(0), 64'h0000_0000_0002_0001);
`else
    exp_n = 0;
`endif
    check("t6_nwords", 64'(got.size()), 64'(exp_n));
    check("t6_cnt", 64'(ds_word_cnt_o), 64'(exp_n));
    feed(10, 8);
    tick(4);
    check("t6_idle_nwords", 64'(got.size()), 64'(exp_n));
    check("t6_idle_cnt", 64'(ds_word_cnt_o), 64'(exp_n));
    laser_start_i = 1'b1;
    tick();
    ds_data_rdy_i = 1'b0;
    feed(1, 4);
    tick(2);
    check("t6_run_vld", 64'(ds_data_vld_o), 64'd1);
    check("t6_run_cnt", 64'(ds_word_cnt_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_rst_vld", 64'(ds_data_vld_o), 64'd0);
    check("t6_rst_data", ds_data_o, 64'd0);
    check("t6_rst_cnt", 64'(ds_word_cnt_o), 64'd0);
    check("t6_rst_ovf", 64'(ds_overflow_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
